// File: rtl/instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch                                                        |
// | Word fetcher with req/ack memory port, 2-entry prefetch queue, redirect. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  program_counter_inc,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [31:0]           instruction,
    output logic                  instruction_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            r_count;
    logic                  r_valid;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [31:0]           r_q0_word;
    logic [ADDR_WIDTH-1:0] r_q0_addr;
    logic [31:0]           r_q1_word;
    logic [ADDR_WIDTH-1:0] r_q1_addr;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_credit;
    logic [1:0]            w_count_next;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_pend_next;

    always_comb begin
        w_pop  = (r_count != 2'd0) && program_counter_inc && !pc_load;
        w_push = (r_state == c_ST_REQ) && mem_ack && !pc_load;
        if (pc_load) begin
            w_count_next = 2'd0;
        end else begin
            w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
        // A new request needs room for its word once it lands.
        w_credit = (w_count_next < 2'd2);
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_mem_addr;
        w_pend_next  = r_pend_addr;
        case (r_state)
            c_ST_IDLE: begin
                if (pc_load) begin
                    w_state_next = c_ST_REQ;
                    w_addr_next  = pc_load_value;
                end else if (w_credit) begin
                    w_state_next = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (mem_ack) begin
                    w_addr_next  = pc_load ? pc_load_value : r_mem_addr + 1'b1;
                    w_state_next = (pc_load || w_credit) ? c_ST_REQ : c_ST_IDLE;
                end else if (pc_load) begin
                    // In-flight read cannot be aborted; drop its data later.
                    w_state_next = c_ST_DISCARD;
                    w_pend_next  = pc_load_value;
                end
            end
            c_ST_DISCARD: begin
                if (pc_load) begin
                    w_pend_next = pc_load_value;
                end
                if (mem_ack) begin
                    w_state_next = c_ST_REQ;
                    w_addr_next  = pc_load ? pc_load_value : r_pend_addr;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= RESET_PC;
            r_pend_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_mem_req   <= (w_state_next != c_ST_IDLE);
            r_mem_addr  <= w_addr_next;
            r_pend_addr <= w_pend_next;
        end
    end

    // Shift-style queue: entry 0 is always the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_valid   <= 1'b0;
            r_q0_word <= 32'd0;
            r_q0_addr <= RESET_PC;
            r_q1_word <= 32'd0;
            r_q1_addr <= RESET_PC;
        end else begin
            r_count <= w_count_next;
            r_valid <= (w_count_next != 2'd0);
            if (!pc_load) begin
                if (w_pop && w_push) begin
                    if (r_count == 2'd1) begin
                        r_q0_word <= mem_rdata;
                        r_q0_addr <= r_mem_addr;
                    end else begin
                        r_q0_word <= r_q1_word;
                        r_q0_addr <= r_q1_addr;
                        r_q1_word <= mem_rdata;
                        r_q1_addr <= r_mem_addr;
                    end
                end else if (w_pop) begin
                    if (r_count == 2'd2) begin
                        r_q0_word <= r_q1_word;
                        r_q0_addr <= r_q1_addr;
                    end
                end else if (w_push) begin
                    if (r_count == 2'd0) begin
                        r_q0_word <= mem_rdata;
                        r_q0_addr <= r_mem_addr;
                    end else begin
                        r_q1_word <= mem_rdata;
                        r_q1_addr <= r_mem_addr;
                    end
                end
            end
        end
    end

    assign instruction       = r_q0_word;
    assign pc                = r_q0_addr;
    assign instruction_valid = r_valid;
    assign mem_req           = r_mem_req;
    assign mem_addr          = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch                                                     |
// | Directed self-checking bench for instruction_fetch.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic [15:0] pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;

    logic        inc2 = 1'b0;
    logic [31:0] instruction2;
    logic        instruction_valid2;
    logic [15:0] pc2;
    logic        mem_req2;
    logic [15:0] mem_addr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = {16'h0, mem_addr} + 32'h1000;

    instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .program_counter_inc(inc),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .pc(pc), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .program_counter_inc(inc2),
        .pc_load(1'b0), .pc_load_value(16'h0),
        .instruction(instruction2), .instruction_valid(instruction_valid2),
        .pc(pc2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_req2), .mem_rdata({16'h0, mem_addr2} + 32'h1000)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; inc = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0;
        auto_ack = 1'b0; man_ack = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if ({instruction, instruction_valid, pc, mem_req, mem_addr} !== {32'h0, 1'b0, 16'h0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_main: got instr=%h v=%b pc=%h req=%b addr=%h, want 0/0/0/0/0",
                     instruction, instruction_valid, pc, mem_req, mem_addr);
        end
        checks++;
        if ({instruction2, instruction_valid2, pc2, mem_req2, mem_addr2} !== {32'h0, 1'b0, 16'hFFFE, 1'b0, 16'hFFFE}) begin
            errors++;
            $display("FAIL reset_wrap: got instr=%h v=%b pc=%h req=%b addr=%h, want 0/0/fffe/0/fffe",
                     instruction2, instruction_valid2, pc2, mem_req2, mem_addr2);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        auto_ack = 1'b1; inc = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_addr, instruction_valid} !== {1'b1, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL stream_first_req: got req=%b addr=%h v=%b, want 1/0000/0", mem_req, mem_addr, instruction_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({instruction_valid, pc, instruction} !== {1'b1, 16'(i), 32'h1000 + 32'(i)}) begin
                errors++;
                $display("FAIL stream_word%0d: got v=%b pc=%h instr=%h, want 1/%h/%h",
                         i, instruction_valid, pc, instruction, 16'(i), 32'h1000 + 32'(i));
            end
        end
        inc = 1'b0; auto_ack = 1'b0;
    endtask

    task automatic test_no_pop();
        apply_reset();
        auto_ack = 1'b1;
        repeat (2) step();
        checks++;
        if ({mem_req, mem_addr, instruction_valid, pc} !== {1'b1, 16'h1, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL nopop_one: got req=%b addr=%h v=%b pc=%h, want 1/0001/1/0000", mem_req, mem_addr, instruction_valid, pc);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req, mem_addr, instruction, pc} !== {1'b0, 16'h2, 32'h1000, 16'h0}) begin
                errors++;
                $display("FAIL nopop_full%0d: got req=%b addr=%h instr=%h pc=%h, want 0/0002/00001000/0000",
                         i, mem_req, mem_addr, instruction, pc);
            end
            step();
        end
        inc = 1'b1;
        step();
        inc = 1'b0;
        checks++;
        if ({mem_req, mem_addr, instruction, pc} !== {1'b1, 16'h2, 32'h1001, 16'h1}) begin
            errors++;
            $display("FAIL nopop_release: got req=%b addr=%h instr=%h pc=%h, want 1/0002/00001001/0001",
                     mem_req, mem_addr, instruction, pc);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req, mem_addr, pc} !== {1'b0, 16'h3, 16'h1}) begin
                errors++;
                $display("FAIL nopop_refull%0d: got req=%b addr=%h pc=%h, want 0/0003/0001", i, mem_req, mem_addr, pc);
            end
            step();
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_redirect_discard();
        apply_reset();
        pc_load = 1'b1; pc_load_value = 16'h5;
        step();
        pc_load = 1'b0;
        checks++;
        if ({mem_req, mem_addr, instruction_valid} !== {1'b1, 16'h5, 1'b0}) begin
            errors++;
            $display("FAIL disc_req5: got req=%b addr=%h v=%b, want 1/0005/0", mem_req, mem_addr, instruction_valid);
        end
        pc_load = 1'b1; pc_load_value = 16'h40;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem_req, mem_addr, instruction_valid} !== {1'b1, 16'h5, 1'b0}) begin
                errors++;
                $display("FAIL disc_hold%0d: got req=%b addr=%h v=%b, want 1/0005/0", i, mem_req, mem_addr, instruction_valid);
            end
            step();
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        checks++;
        if ({mem_req, mem_addr, instruction_valid} !== {1'b1, 16'h40, 1'b0}) begin
            errors++;
            $display("FAIL disc_newreq: got req=%b addr=%h v=%b, want 1/0040/0", mem_req, mem_addr, instruction_valid);
        end
        repeat (3) begin
            step();
            checks++;
            if (instruction_valid !== 1'b0) begin
                errors++;
                $display("FAIL disc_stale_visible: got v=%b pc=%h, want v=0", instruction_valid, pc);
            end
        end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        checks++;
        if ({instruction_valid, pc, instruction} !== {1'b1, 16'h40, 32'h1040}) begin
            errors++;
            $display("FAIL disc_first: got v=%b pc=%h instr=%h, want 1/0040/00001040", instruction_valid, pc, instruction);
        end
    endtask

    task automatic test_redirect_with_ack();
        apply_reset();
        auto_ack = 1'b1;
        repeat (2) step();
        pc_load = 1'b1; pc_load_value = 16'h10; inc = 1'b1;
        step();
        pc_load = 1'b0; inc = 1'b0;
        checks++;
        if ({instruction_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h10}) begin
            errors++;
            $display("FAIL ackload_flush: got v=%b req=%b addr=%h, want 0/1/0010", instruction_valid, mem_req, mem_addr);
        end
        step();
        checks++;
        if ({instruction_valid, pc, instruction} !== {1'b1, 16'h10, 32'h1010}) begin
            errors++;
            $display("FAIL ackload_first: got v=%b pc=%h instr=%h, want 1/0010/00001010", instruction_valid, pc, instruction);
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_wrap();
        inc2 = 1'b1;
        apply_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp_pc;
            exp_pc = 16'hFFFE + 16'(i);
            step();
            checks++;
            if ({instruction_valid2, pc2, instruction2} !== {1'b1, exp_pc, {16'h0, exp_pc} + 32'h1000}) begin
                errors++;
                $display("FAIL wrap_word%0d: got v=%b pc=%h instr=%h, want 1/%h/%h",
                         i, instruction_valid2, pc2, instruction2, exp_pc, {16'h0, exp_pc} + 32'h1000);
            end
        end
        inc2 = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        step();
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        step();
        checks++;
        if ({instruction_valid, mem_req, mem_addr, pc} !== {1'b1, 1'b1, 16'h1, 16'h0}) begin
            errors++;
            $display("FAIL areset_setup: got v=%b req=%b addr=%h pc=%h, want 1/1/0001/0000", instruction_valid, mem_req, mem_addr, pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instruction, instruction_valid, pc, mem_req, mem_addr} !== {32'h0, 1'b0, 16'h0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL areset_now: got instr=%h v=%b pc=%h req=%b addr=%h, want 0/0/0/0/0",
                     instruction, instruction_valid, pc, mem_req, mem_addr);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_no_pop();
        test_redirect_discard();
        test_redirect_with_ack();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
